// File: rtl/frame_serializer.sv
// Snapshots a 4x4 frame of words on start and streams it as 16 words over valid/ready,
// half 0 (cols 0-1 of each row) first, then half 1. Optional FRAME_SERIALIZER_PARITY_EN adds dout_parity.
module frame_serializer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] frame_0_in,
  input  logic [WORD_W-1:0] frame_1_in,
  input  logic [WORD_W-1:0] frame_2_in,
  input  logic [WORD_W-1:0] frame_3_in,
  input  logic [WORD_W-1:0] frame_4_in,
  input  logic [WORD_W-1:0] frame_5_in,
  input  logic [WORD_W-1:0] frame_6_in,
  input  logic [WORD_W-1:0] frame_7_in,
  input  logic [WORD_W-1:0] frame_8_in,
  input  logic [WORD_W-1:0] frame_9_in,
  input  logic [WORD_W-1:0] frame_10_in,
  input  logic [WORD_W-1:0] frame_11_in,
  input  logic [WORD_W-1:0] frame_12_in,
  input  logic [WORD_W-1:0] frame_13_in,
  input  logic [WORD_W-1:0] frame_14_in,
  input  logic [WORD_W-1:0] frame_15_in,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_half,
  output logic              dout_last,
  output logic              busy,
  output logic              done
`ifdef FRAME_SERIALIZER_PARITY_EN
  ,
  output logic              dout_parity
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [WORD_W-1:0] buf_q [16];
  logic [WORD_W-1:0] buf_d [16];
  logic [WORD_W-1:0] frame_in [16];
  logic [3:0]        rd_idx;

  assign frame_in[0]  = frame_0_in;
  assign frame_in[1]  = frame_1_in;
  assign frame_in[2]  = frame_2_in;
  assign frame_in[3]  = frame_3_in;
  assign frame_in[4]  = frame_4_in;
  assign frame_in[5]  = frame_5_in;
  assign frame_in[6]  = frame_6_in;
  assign frame_in[7]  = frame_7_in;
  assign frame_in[8]  = frame_8_in;
  assign frame_in[9]  = frame_9_in;
  assign frame_in[10] = frame_10_in;
  assign frame_in[11] = frame_11_in;
  assign frame_in[12] = frame_12_in;
  assign frame_in[13] = frame_13_in;
  assign frame_in[14] = frame_14_in;
  assign frame_in[15] = frame_15_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          buf_d   = frame_in;
          cnt_d   = 4'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (dout_ready) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      buf_q   <= buf_d;
    end
  end

  // Row = cnt[2:1], column-within-half = cnt[0], half selects column pair 0-1 or 2-3.
  assign rd_idx     = {cnt_q[2:1], cnt_q[3], cnt_q[0]};
  assign busy       = (state_q == SEND);
  assign dout_valid = busy;
  assign dout       = dout_valid ? buf_q[rd_idx] : '0;
  assign dout_half  = cnt_q[3];
  assign dout_last  = (cnt_q == 4'd15) && dout_valid;
  assign done       = done_q;

`ifdef FRAME_SERIALIZER_PARITY_EN
  assign dout_parity = ^dout;
`endif

endmodule

// File: tb/tb_frame_serializer.sv
// Randomized/directed bench for frame_serializer against a row/half ordering model.
module tb_frame_serializer;
  logic        clk = 1'b0;
  logic        rst, start, dout_ready;
  logic [31:0] fr [16];
  logic [31:0] dout;
  logic        dout_valid, dout_half, dout_last, busy, done;
`ifdef FRAME_SERIALIZER_PARITY_EN
  logic        dout_parity;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_serializer #(.WORD_W(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .frame_0_in(fr[0]),   .frame_1_in(fr[1]),   .frame_2_in(fr[2]),   .frame_3_in(fr[3]),
    .frame_4_in(fr[4]),   .frame_5_in(fr[5]),   .frame_6_in(fr[6]),   .frame_7_in(fr[7]),
    .frame_8_in(fr[8]),   .frame_9_in(fr[9]),   .frame_10_in(fr[10]), .frame_11_in(fr[11]),
    .frame_12_in(fr[12]), .frame_13_in(fr[13]), .frame_14_in(fr[14]), .frame_15_in(fr[15]),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_half(dout_half), .dout_last(dout_last), .busy(busy), .done(done)
`ifdef FRAME_SERIALIZER_PARITY_EN
    , .dout_parity(dout_parity)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input logic [31:0] w [16]);
    for (int i = 0; i < 16; i++) fr[i] = w[i];
  endtask

  // Called right after a negedge; returns in the first-valid cycle (after the next negedge).
  task automatic start_frame(input bit hold, input bit clobber);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    if (clobber) for (int i = 0; i < 16; i++) fr[i] = 32'hFFFF_FFFF;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  // mode 0: ready high, 1: 5-cycle stall at word 3 then toggle, 2: random ready, 3: reset at word 9
  task automatic drain(input logic [31:0] snap [16], input int mode);
    logic [31:0] exp_q [$];
    int k = 0, cyc = 0, stall = 0;
    bit tog = 1'b0, rdy;
    for (int h = 0; h < 2; h++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 2; c++) exp_q.push_back(snap[r*4 + h*2 + c]);
    while (k < 16 && cyc < 400) begin
      cyc++;
      if (mode == 3 && k == 9) begin
        rst = 1'b1;
        #1;
        chk("rst_dout", {32'd0, dout}, 64'd0);
        chk("rst_valid", {63'd0, dout_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_half_last_done", {61'd0, dout_half, dout_last, done}, 64'd0);
        @(negedge clk);
        chk("rst_no_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        dout_ready = 1'b0;
        return;
      end
      chk("valid", {63'd0, dout_valid}, 64'd1);
      chk("dout", {32'd0, dout}, {32'd0, exp_q[k]});
      chk("half", {63'd0, dout_half}, {63'd0, (k >= 8)});
      chk("last", {63'd0, dout_last}, {63'd0, (k == 15)});
`ifdef FRAME_SERIALIZER_PARITY_EN
      chk("parity", {63'd0, dout_parity}, {63'd0, ^exp_q[k]});
`endif
      case (mode)
        1: begin
          if (k == 3 && stall < 5) begin rdy = 1'b0; stall++; end
          else if (k > 3) begin rdy = tog; tog = ~tog; end
          else rdy = 1'b1;
        end
        2: rdy = ($urandom_range(0, 3) != 0);
        default: rdy = 1'b1;
      endcase
      dout_ready = rdy;
      @(negedge clk);
      if (rdy) k++;
    end
    if (k < 16) chk("drain_timeout", 64'(k), 64'd16);
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("done_busy_low", {62'd0, busy, dout_valid}, 64'd0);
    dout_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] base [16];
    logic [31:0] rnd [16];
    rst = 1'b1; start = 1'b0; dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin base[i] = 32'hA000_0000 + i; fr[i] = '0; end
    #2;
    chk("reset_dout", {32'd0, dout}, 64'd0);
    chk("reset_flags", {58'd0, dout_valid, dout_half, dout_last, busy, done, 1'b0}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_busy", {63'd0, busy}, 64'd0);

    // basic frame
    load_frame(base);
    start_frame(1'b0, 1'b0);
    drain(base, 0);
    @(negedge clk);
    // backpressure
    start_frame(1'b0, 1'b0);
    drain(base, 1);
    @(negedge clk);
    // snapshot isolation
    start_frame(1'b0, 1'b1);
    drain(base, 0);
    load_frame(base);
    @(negedge clk);
    // start held: back-to-back with a one-cycle busy gap
    start_frame(1'b1, 1'b0);
    drain(base, 0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    drain(base, 0);
    @(negedge clk);
    chk("idle_after_b2b", {63'd0, busy}, 64'd0);
    // random frames with random backpressure
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 16; i++) rnd[i] = $urandom;
      load_frame(rnd);
      start_frame(1'b0, 1'b0);
      drain(rnd, 2);
      if (f[0]) @(negedge clk);
    end
    @(negedge clk);
    // reset mid-frame then a complete frame
    load_frame(base);
    start_frame(1'b0, 1'b0);
    drain(base, 3);
    @(negedge clk);
    chk("post_rst_idle", {63'd0, busy}, 64'd0);
    start_frame(1'b0, 1'b0);
    drain(base, 0);
`ifdef FRAME_SERIALIZER_PARITY_EN
    @(negedge clk);
    rnd = base;
    rnd[0] = 32'h0000_0007; rnd[1] = 32'h0000_0003;
    load_frame(rnd);
    start_frame(1'b0, 1'b0);
    chk("parity_7", {63'd0, dout_parity}, 64'd1);
    drain(rnd, 0);
`endif
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
